ipbase_intf_axi_rd_adapter_simplified: RTL and testbench

IPBASE_INTF_AXI_RD_ADAPTER_SIMPLIFIED -- requirements
Module: ipbase_intf_axi_rd_adapter_simplified

---
 rtl/ipbase_intf_axi_rd_adapter_simplified.sv | 198 +++++++++++++++++++
 tb/tb_ipbase_intf_axi_rd_adapter_simplified.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipbase_intf_axi_rd_adapter_simplified.sv
// Command-to-AXI4 read adapter: splits a 1..256 beat read into 4 KB-safe AR bursts and returns data
// through a 2-entry skid buffer. Optional debug counters are enabled with IPBASE_AXI_RD_DFX_EN.
`timescale 1ns/1ps
module ipbase_intf_axi_rd_adapter_simplified #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int TLEN_WIDTH = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [ADDR_WIDTH-1:0] cmd_araddr,
  input  logic [TLEN_WIDTH-1:0] cmd_arlen,
  input  logic                  cmd_arvalid,
  output logic                  cmd_arready,
  output logic [DATA_WIDTH-1:0] cmd_rdata,
  output logic                  cmd_rlast,
  output logic                  cmd_rvalid,
  input  logic                  cmd_rready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  output logic                  err_trig,
  output logic [31:0]           dfx_sta
);

  localparam int LINE_W = ADDR_WIDTH - 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  alive_q;
  logic                  arvalid_q, arvalid_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [8:0]            remaining_q, remaining_d;
  logic [8:0]            total_q, total_d;
  logic [8:0]            out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [5:0] room;
  logic [8:0] rem_m1;
  logic [7:0] ar_len;
  logic [8:0] burst_beats;
  logic       ar_hs, final_ar, r_push, r_pop, last_pop;

  // Sub-line address bits and the slave's burst-level rlast carry no information here.
  logic unused_in;
  assign unused_in = ^{axi_rlast, cmd_araddr[5:0]};

  // Burst length is capped by both the beats left and the lines left before the next 4 KB page.
  assign room        = 6'd63 - line_q[5:0];
  assign rem_m1      = remaining_q - 9'd1;
  assign ar_len      = (rem_m1 < {3'b000, room}) ? rem_m1[7:0] : {2'b00, room};
  assign burst_beats = {1'b0, ar_len} + 9'd1;

  assign axi_araddr  = {line_q, 6'd0};
  assign axi_arlen   = ar_len;
  assign axi_arvalid = arvalid_q;

  assign cmd_arready = alive_q && (state_q == ST_IDLE);
  assign axi_rready  = alive_q && (cnt_q != 2'd2);
  assign cmd_rvalid  = (cnt_q != 2'd0);
  assign cmd_rdata   = buf_q[rd_ptr_q];
  assign cmd_rlast   = cmd_rvalid && ((out_cnt_q + 9'd1) == total_q);
  assign err_trig    = err_q;

  assign ar_hs    = arvalid_q && axi_arready;
  assign final_ar = ar_hs && (remaining_q == burst_beats);
  assign r_push   = axi_rvalid && axi_rready;
  assign r_pop    = cmd_rvalid && cmd_rready;
  assign last_pop = r_pop && cmd_rlast;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    arvalid_d   = arvalid_q;
    line_d      = line_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    out_cnt_d   = out_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_arvalid && cmd_arready) begin
          line_d      = cmd_araddr[ADDR_WIDTH-1:6];
          remaining_d = 9'(cmd_arlen) + 9'd1;
          total_d     = 9'(cmd_arlen) + 9'd1;
          out_cnt_d   = 9'd0;
          arvalid_d   = 1'b1;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ar_hs) begin
          line_d      = line_q + LINE_W'(burst_beats);
          remaining_d = remaining_q - burst_beats;
          if (final_ar) begin
            arvalid_d = 1'b0;
            state_d   = last_pop ? ST_IDLE : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (last_pop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (r_pop) out_cnt_d = last_pop ? 9'd0 : out_cnt_q + 9'd1;
  end

  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + {1'b0, r_push} - {1'b0, r_pop};
    if (r_push) begin
      buf_d[wr_ptr_q] = axi_rdata;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (r_pop) rd_ptr_d = ~rd_ptr_q;
    err_d = r_push && (axi_rresp != 2'b00);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      alive_q     <= 1'b0;
      arvalid_q   <= 1'b0;
      line_q      <= '0;
      remaining_q <= '0;
      total_q     <= '0;
      out_cnt_q   <= '0;
      // NOTE: the data entries are reset because cmd_rdata must read zero during reset.
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alive_q     <= 1'b1;
      arvalid_q   <= arvalid_d;
      line_q      <= line_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      out_cnt_q   <= out_cnt_d;
      buf_q       <= buf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

`ifdef IPBASE_AXI_RD_DFX_EN
  logic        err_sticky_q, err_sticky_d;
  logic [7:0]  ar_cnt_q, ar_cnt_d;
  logic [15:0] rerr_cnt_q, rerr_cnt_d;

  always_comb begin
    err_sticky_d = err_sticky_q | err_d;
    ar_cnt_d     = (ar_hs && ar_cnt_q != 8'hFF) ? ar_cnt_q + 8'd1 : ar_cnt_q;
    rerr_cnt_d   = (err_d && rerr_cnt_q != 16'hFFFF) ? rerr_cnt_q + 16'd1 : rerr_cnt_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_sticky_q <= 1'b0;
      ar_cnt_q     <= '0;
      rerr_cnt_q   <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      ar_cnt_q     <= ar_cnt_d;
      rerr_cnt_q   <= rerr_cnt_d;
    end
  end

  assign dfx_sta = {err_sticky_q, state_q, 5'd0, ar_cnt_q, rerr_cnt_q};
`else
  assign dfx_sta = 32'd0;
`endif

endmodule

// File: tb/tb_ipbase_intf_axi_rd_adapter_simplified.sv
// Randomized bench for the AXI read adapter: a page-splitting burst planner, an AXI slave model and
// a beat scoreboard predict every AR, returned beat, rlast, err_trig and buffer-occupancy effect.
`timescale 1ns/1ps
module tb_ipbase_intf_axi_rd_adapter_simplified;

  localparam int DW = 512;
  localparam int AW = 32;
  localparam int TW = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [AW-1:0] cmd_araddr;
  logic [TW-1:0] cmd_arlen;
  logic          cmd_arvalid;
  logic          cmd_arready;
  logic [DW-1:0] cmd_rdata;
  logic          cmd_rlast;
  logic          cmd_rvalid;
  logic          cmd_rready;
  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rlast;
  logic          axi_rvalid;
  logic          axi_rready;
  logic          err_trig;
  logic [31:0]   dfx_sta;

  ipbase_intf_axi_rd_adapter_simplified #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TLEN_WIDTH(TW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_araddr(cmd_araddr), .cmd_arlen(cmd_arlen), .cmd_arvalid(cmd_arvalid), .cmd_arready(cmd_arready),
    .cmd_rdata(cmd_rdata), .cmd_rlast(cmd_rlast), .cmd_rvalid(cmd_rvalid), .cmd_rready(cmd_rready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready), .err_trig(err_trig), .dfx_sta(dfx_sta)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] addr;
    int          len;
  } ar_t;

  int n_checks = 0;
  int n_errors = 0;

  ar_t           exp_ar[$];
  logic [DW-1:0] exp_data[$];
  int            burst_q[$];
  int            beat_in_burst, occ, sent;
  bit            rv_acc, err_prev, sticky_exp;
  int            err_cnt_exp, ar_cnt_exp;
  int            ar_p, rv_p, rr_p, err_p, force_err_beat;
  bit            toggle_rr;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  // Walk the command byte range, cutting a burst at every 4 KB page end.
  task automatic plan(input logic [31:0] addr, input int len);
    logic [31:0] a;
    int rem, room, n;
    a   = addr & ~32'h3F;
    rem = len + 1;
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / 64;
      n    = (rem < room) ? rem : room;
      exp_ar.push_back('{a, n - 1});
      a   = a + 32'(n * 64);
      rem = rem - n;
    end
  endtask

  task automatic check_dfx(input string tag);
`ifdef IPBASE_AXI_RD_DFX_EN
    check({tag, "_dfx_errcnt"}, dfx_sta[15:0], err_cnt_exp);
    check({tag, "_dfx_arcnt"}, dfx_sta[23:16], (ar_cnt_exp > 255) ? 255 : ar_cnt_exp);
    check({tag, "_dfx_sticky"}, dfx_sta[31], sticky_exp);
`else
    check({tag, "_dfx_zero"}, dfx_sta, 32'd0);
`endif
  endtask

  task automatic reset_model();
    exp_ar.delete();
    exp_data.delete();
    burst_q.delete();
    beat_in_burst = 0; occ = 0; sent = 0;
    rv_acc = 0; err_prev = 0; sticky_exp = 0;
    err_cnt_exp = 0; ar_cnt_exp = 0;
  endtask

  // Runs one command to completion; called with the bench parked on a falling edge.
  task automatic run_cmd(input logic [31:0] addr, input int len);
    int total, got, cyc;
    bit tog, r_hs, c_hs;
    plan(addr, len);
    total = len + 1;
    got = 0; sent = 0; cyc = 0; tog = 1'b1;
    check("cmd_arready_idle", cmd_arready, 1'b1);
    cmd_araddr  = addr;
    cmd_arlen   = TW'(len);
    cmd_arvalid = 1'b1;
    @(negedge sys_clk);
    cmd_arvalid = 1'b0;
    cmd_araddr  = $urandom();
    cmd_arlen   = TW'($urandom());
    check("arvalid_first", axi_arvalid, 1'b1);
    while (got < total && cyc < 20000) begin
      check("cmd_arready_busy", cmd_arready, 1'b0);
      check("axi_rready_occ", axi_rready, occ < 2);
      check("cmd_rvalid_occ", cmd_rvalid, occ > 0);
      check("err_trig", err_trig, err_prev);
      // Slave R channel: only bursts whose AR was accepted on an earlier edge can return data.
      if (rv_acc) begin
        axi_rvalid = 1'b0;
        rv_acc     = 1'b0;
      end
      if (!axi_rvalid && burst_q.size() > 0 && $urandom_range(99) < rv_p) begin
        axi_rdata  = rand_data();
        axi_rresp  = (sent == force_err_beat) ? 2'd2 :
                     ($urandom_range(99) < err_p) ? 2'($urandom_range(1, 3)) : 2'd0;
        axi_rlast  = (beat_in_burst == burst_q[0] - 1);
        axi_rvalid = 1'b1;
      end
      r_hs = axi_rvalid && axi_rready;
      err_prev = r_hs && (axi_rresp != 2'd0);
      if (r_hs) begin
        exp_data.push_back(axi_rdata);
        sent++;
        beat_in_burst++;
        if (beat_in_burst == burst_q[0]) begin
          void'(burst_q.pop_front());
          beat_in_burst = 0;
        end
        rv_acc = 1'b1;
        if (err_prev) begin
          err_cnt_exp++;
          sticky_exp = 1'b1;
        end
      end
      // Command-side consumer.
      if (toggle_rr) begin
        cmd_rready = tog;
        tog = !tog;
      end else begin
        cmd_rready = ($urandom_range(99) < rr_p);
      end
      c_hs = 1'b0;
      if (cmd_rvalid) begin
        if (exp_data.size() > 0) begin
          check("cmd_rdata", cmd_rdata, exp_data[0]);
          check("cmd_rlast", cmd_rlast, (got + 1) == total);
        end else begin
          check("cmd_rvalid_spurious", cmd_rvalid, 1'b0);
        end
        if (cmd_rready && exp_data.size() > 0) begin
          void'(exp_data.pop_front());
          got++;
          c_hs = 1'b1;
        end
      end
      occ = occ + int'(r_hs) - int'(c_hs);
      // Slave AR channel.
      axi_arready = ($urandom_range(99) < ar_p);
      if (axi_arvalid && axi_arready) begin
        if (exp_ar.size() == 0) begin
          check("ar_extra", axi_arvalid, 1'b0);
        end else begin
          check("axi_araddr", axi_araddr, exp_ar[0].addr);
          check("axi_arlen", axi_arlen, exp_ar[0].len);
          burst_q.push_back(exp_ar[0].len + 1);
          void'(exp_ar.pop_front());
          ar_cnt_exp++;
        end
      end
      @(negedge sys_clk);
      cyc++;
    end
    check("cmd_beats", got, total);
    check("ar_all_issued", exp_ar.size(), 0);
    cmd_rready  = 1'b0;
    axi_arready = 1'b0;
    if (rv_acc) axi_rvalid = 1'b0;
    rv_acc = 1'b0;
    check("err_trig_tail", err_trig, err_prev);
    err_prev = 1'b0;
    check("arvalid_done", axi_arvalid, 1'b0);
    check_dfx("cmd_end");
    force_err_beat = -1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    sys_rst_n = 1'b0;
    cmd_araddr = '0; cmd_arlen = '0; cmd_arvalid = 1'b0; cmd_rready = 1'b0;
    axi_arready = 1'b0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0; axi_rvalid = 1'b0;
    ar_p = 100; rv_p = 100; rr_p = 100; err_p = 0; force_err_beat = -1; toggle_rr = 1'b0;
    reset_model();
    repeat (3) @(negedge sys_clk);
    check("rst_cmd_arready", cmd_arready, 1'b0);
    check("rst_axi_rready", axi_rready, 1'b0);
    check("rst_axi_arvalid", axi_arvalid, 1'b0);
    check("rst_cmd_rvalid", cmd_rvalid, 1'b0);
    check("rst_cmd_rlast", cmd_rlast, 1'b0);
    check("rst_cmd_rdata", cmd_rdata, '0);
    check("rst_err_trig", err_trig, 1'b0);
    check("rst_dfx", dfx_sta, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("rel_cmd_arready", cmd_arready, 1'b1);
    check("rel_axi_rready", axi_rready, 1'b1);

    // Single aligned 64-beat burst at full throughput.
    run_cmd(32'h0000_1000, 63);
    // Page crossing with an error response on beat 2.
    ar_p = 80; rv_p = 80; rr_p = 80; force_err_beat = 1;
    run_cmd(32'h0000_1FC0, 3);
    // Maximum length spanning five bursts.
    ar_p = 70; rv_p = 90; rr_p = 75;
    run_cmd(32'h0000_0F80, 255);
    // Consumer toggles every cycle while the slave streams continuously.
    ar_p = 100; rv_p = 100; toggle_rr = 1'b1;
    run_cmd(32'h0000_2340, 40);
    toggle_rr = 1'b0;

    for (int i = 0; i < 8; i++) begin
      ar_p  = $urandom_range(30, 100);
      rv_p  = $urandom_range(30, 100);
      rr_p  = $urandom_range(30, 100);
      err_p = 10;
      run_cmd($urandom(), ($urandom_range(3) == 0) ? 255 : $urandom_range(0, 255));
    end

    // Reset while bursts of a long command are still being issued.
    err_p = 0; ar_p = 0; rv_p = 100; rr_p = 100;
    cmd_araddr = 32'h0000_0F80; cmd_arlen = 8'd255; cmd_arvalid = 1'b1;
    @(negedge sys_clk);
    cmd_arvalid = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("mid_arvalid_held", axi_arvalid, 1'b1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("mid_rst_arvalid", axi_arvalid, 1'b0);
    check("mid_rst_cmd_rvalid", cmd_rvalid, 1'b0);
    check("mid_rst_cmd_arready", cmd_arready, 1'b0);
    check("mid_rst_dfx", dfx_sta, 32'd0);
    reset_model();
    axi_rvalid = 1'b0; axi_arready = 1'b0; cmd_rready = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("mid_rel_cmd_arready", cmd_arready, 1'b1);
    check("mid_rel_axi_rready", axi_rready, 1'b1);
    check("mid_rel_arvalid", axi_arvalid, 1'b0);
    ar_p = 90; rv_p = 90; rr_p = 90;
    run_cmd(32'h0000_5000, 7);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
